// File: rtl/ucy_74160.sv
// ----------------------------------------------------------------------------
// ucy_74160 -- pin-level model of the UCY74160 synchronous decade counter.
//
// Four-bit counter with synchronous parallel load, asynchronous clear and a
// combinational ripple-carry output for building multi-digit counters.
// Q = {QD,QC,QB,QA} drives the A..D inputs of the downstream ucy_7442 decoder.
//
// Parameter MODULUS selects 74160 (10) or 74161 (16) behaviour; only these two
// values are meaningful.
//
// Optional macro UCY_74160_SILICON_DECODE_EN (MODULUS 10 only):
//   defined   -> RCO decodes only QA & QD, and states 10..15 step the way the
//                real silicon does (10->11->6, 12->13->4, 14->15->2).
//   undefined -> RCO decodes Q == MODULUS-1 exactly, and any out-of-range
//                state goes to 0 on the next count.
//
// Pin map: p1 CLR_n, p2 CLK, p3..p6 A..D, p7 ENP, p9 LOAD_n, p10 ENT,
//          p11..p14 QD..QA, p15 RCO; p8/p16 are supply pins and are ignored.
// ----------------------------------------------------------------------------
module ucy_74160 #(
   parameter int MODULUS = 10
) (
   input  logic p1,   // CLR_n, asynchronous active-low clear
   input  logic p2,   // CLK, rising edge
   input  logic p3,   // A, load data bit 0
   input  logic p4,   // B, load data bit 1
   input  logic p5,   // C, load data bit 2
   input  logic p6,   // D, load data bit 3
   input  logic p7,   // ENP, parallel count enable
   input  logic p8,   // GND, ignored
   input  logic p9,   // LOAD_n, synchronous load, active-low
   input  logic p10,  // ENT, trickle count enable, also gates RCO
   output logic p11,  // QD (bit 3)
   output logic p12,  // QC
   output logic p13,  // QB
   output logic p14,  // QA (bit 0)
   output logic p15,  // RCO, ripple carry out
   input  logic p16   // VCC, ignored
);

   // Terminal count: the state at which the counter wraps and RCO fires.
   localparam logic [3:0] LP_TERM = 4'(MODULUS - 1);

   logic [3:0] r_q;
   logic [3:0] w_next;
   logic [3:0] w_load_val;
   logic       w_count_en;
   logic       w_rco;
   logic       w_unused_pins;

   // Supply pins carry no logic; fold them into a sink so they are consumed.
   assign w_unused_pins = p8 ^ p16;

   assign w_load_val = {p6, p5, p4, p3};
   assign w_count_en = p7 & p10;

   // Successor of the current state when counting is enabled.
   always_comb begin
      w_next = (r_q < LP_TERM) ? (r_q + 4'd1) : 4'd0;
`ifdef UCY_74160_SILICON_DECODE_EN
      // The decade part's gating lets the illegal states chain back into the
      // legal range along fixed paths instead of clearing to 0.
      if (MODULUS == 10) begin
         case (r_q)
            4'd10:   w_next = 4'd11;
            4'd11:   w_next = 4'd6;
            4'd12:   w_next = 4'd13;
            4'd13:   w_next = 4'd4;
            4'd14:   w_next = 4'd15;
            4'd15:   w_next = 4'd2;
            default: w_next = w_next;
         endcase
      end
`endif
   end

   // Ripple carry: combinational from ENT and Q, independent of ENP/LOAD_n.
   always_comb begin
      w_rco = p10 & (r_q == LP_TERM);
`ifdef UCY_74160_SILICON_DECODE_EN
      // Silicon only looks at QA and QD, so 11, 13 and 15 also carry.
      if (MODULUS == 10) begin
         w_rco = p10 & r_q[0] & r_q[3];
      end
`endif
      // Held low during clear; Q is already 0 then, this just makes it explicit.
      w_rco = w_rco & p1;
   end

   // State register: clear beats load, load beats count, otherwise hold.
   always_ff @(posedge p2 or negedge p1) begin
      if (!p1) begin
         r_q <= 4'd0;
      end else if (!p9) begin
         r_q <= w_load_val;
      end else if (w_count_en) begin
         r_q <= w_next;
      end
   end

   assign p11 = r_q[3];
   assign p12 = r_q[2];
   assign p13 = r_q[1];
   assign p14 = r_q[0];
   assign p15 = w_rco;

endmodule

// File: tb/tb_ucy_74160.sv
// ----------------------------------------------------------------------------
// tb_ucy_74160 -- bench for ucy_74160.
// Instances: a decade counter for the vector table and corner sequences, a
// two-digit cascade of decade counters, and a MODULUS 16 counter.
// Expected values honour UCY_74160_SILICON_DECODE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_ucy_74160;

   // ------------------------------------------------------------ clock/reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ main DUT
   logic       ld_n, enp, ent;
   logic [3:0] din;
   wire  [3:0] m_q;
   wire        m_rco;

   ucy_74160 #(.MODULUS(10)) u_dut (
      .p1(rst_n), .p2(clk), .p3(din[0]), .p4(din[1]), .p5(din[2]), .p6(din[3]),
      .p7(enp), .p8(1'b0), .p9(ld_n), .p10(ent),
      .p11(m_q[3]), .p12(m_q[2]), .p13(m_q[1]), .p14(m_q[0]), .p15(m_rco),
      .p16(1'b1)
   );

   // ------------------------------------------------------------ cascade
   logic       c_en;
   wire  [3:0] lo_q, hi_q;
   wire        lo_rco, hi_rco;

   ucy_74160 #(.MODULUS(10)) u_lo (
      .p1(rst_n), .p2(clk), .p3(1'b0), .p4(1'b0), .p5(1'b0), .p6(1'b0),
      .p7(1'b1), .p8(1'b0), .p9(1'b1), .p10(c_en),
      .p11(lo_q[3]), .p12(lo_q[2]), .p13(lo_q[1]), .p14(lo_q[0]), .p15(lo_rco),
      .p16(1'b1)
   );

   ucy_74160 #(.MODULUS(10)) u_hi (
      .p1(rst_n), .p2(clk), .p3(1'b0), .p4(1'b0), .p5(1'b0), .p6(1'b0),
      .p7(1'b1), .p8(1'b0), .p9(1'b1), .p10(lo_rco),
      .p11(hi_q[3]), .p12(hi_q[2]), .p13(hi_q[1]), .p14(hi_q[0]), .p15(hi_rco),
      .p16(1'b1)
   );

   // ------------------------------------------------------------ MODULUS 16
   logic       ld16_n, en16;
   logic [3:0] d16;
   wire  [3:0] h_q;
   wire        h_rco;

   ucy_74160 #(.MODULUS(16)) u_dut16 (
      .p1(rst_n), .p2(clk), .p3(d16[0]), .p4(d16[1]), .p5(d16[2]), .p6(d16[3]),
      .p7(en16), .p8(1'b0), .p9(ld16_n), .p10(en16),
      .p11(h_q[3]), .p12(h_q[2]), .p13(h_q[1]), .p14(h_q[0]), .p15(h_rco),
      .p16(1'b1)
   );

   // ------------------------------------------------------------ bookkeeping
   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard entries are {rco, hi digit, q}; the main/16 counters use 0 for hi.
   logic [8:0] exp_q[$];

   typedef struct {
      logic       ld_n;
      logic [3:0] d;
      logic       enp;
      logic       ent;
      logic [3:0] eq;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic l, input logic [3:0] d, input logic p,
                          input logic t, input logic [3:0] eq, input logic er);
      vec_t v;
      v.ld_n = l; v.d = d; v.enp = p; v.ent = t; v.eq = eq; v.er = er;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_check(input string name, input logic [8:0] act);
      logic [8:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: got %h expected <empty scoreboard> at %0t", name, act, $time);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
         end
      end
   endtask

   // Outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] pk(input logic r, input logic [3:0] h, input logic [3:0] q);
      return {r, h, q};
   endfunction

   // ------------------------------------------------------------ watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      ld_n = 1'b1; din = 4'd0; enp = 1'b0; ent = 1'b0;
      c_en = 1'b0; ld16_n = 1'b1; d16 = 4'd0; en16 = 1'b0;

      // Vector table: {LOAD_n, DCBA, ENP, ENT} -> {Q, RCO} after one edge.
      add_vec(0, 4'd7,  0, 0, 4'd7, 0);   // load ignores disabled enables
      add_vec(1, 4'd0,  1, 1, 4'd8, 0);
      add_vec(1, 4'd0,  1, 1, 4'd9, 1);   // terminal count carries
      add_vec(1, 4'd0,  1, 1, 4'd0, 0);   // 9 -> 0 wrap
      add_vec(0, 4'd9,  0, 0, 4'd9, 0);   // at 9 but ENT low: no carry
      add_vec(1, 4'd0,  0, 1, 4'd9, 1);   // ENP low holds, RCO ignores ENP
      add_vec(1, 4'd0,  1, 0, 4'd9, 0);   // ENT low holds
      add_vec(0, 4'd5,  1, 1, 4'd5, 0);   // load wins over count
      add_vec(1, 4'd0,  1, 1, 4'd6, 0);
      add_vec(0, 4'd12, 0, 0, 4'd12, 0);  // out-of-range load accepted
`ifdef UCY_74160_SILICON_DECODE_EN
      add_vec(1, 4'd0,  1, 1, 4'd13, 1);
      add_vec(1, 4'd0,  1, 1, 4'd4,  0);
      add_vec(0, 4'd15, 0, 1, 4'd15, 1);
      add_vec(1, 4'd0,  1, 1, 4'd2,  0);
      add_vec(0, 4'd10, 0, 0, 4'd10, 0);
      add_vec(1, 4'd0,  1, 1, 4'd11, 1);
      add_vec(1, 4'd0,  1, 1, 4'd6,  0);
`else
      add_vec(1, 4'd0,  1, 1, 4'd0,  0);
      add_vec(1, 4'd0,  1, 1, 4'd1,  0);
      add_vec(0, 4'd15, 0, 1, 4'd15, 0);
      add_vec(1, 4'd0,  1, 1, 4'd0,  0);
      add_vec(0, 4'd10, 0, 0, 4'd10, 0);
      add_vec(1, 4'd0,  1, 1, 4'd0,  0);
      add_vec(1, 4'd0,  1, 1, 4'd1,  0);
`endif

      // Reset: real falling edge on CLR_n, outputs cleared without a clock.
      #2 rst_n = 1'b0;
      #2;
      check("reset_main", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd0));
      check("reset_casc", pk(hi_rco, hi_q, lo_q), pk(1'b0, 4'd0, 4'd0));
      check("reset_m16",  pk(h_rco, 4'd0, h_q), pk(1'b0, 4'd0, 4'd0));

      // Clock with load/count requested while clear held: Q stays 0.
      ld_n = 1'b0; din = 4'd7; enp = 1'b1; ent = 1'b1;
      tick();
      check("reset_hold_load", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd0));
      ld_n = 1'b1;
      tick();
      check("reset_hold_count", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd0));
      @(negedge clk);
      rst_n = 1'b1;
      enp = 1'b0; ent = 1'b0;

      // Table-driven vectors through the scoreboard.
      foreach (vecs[i]) begin
         ld_n = vecs[i].ld_n; din = vecs[i].d; enp = vecs[i].enp; ent = vecs[i].ent;
         exp_q.push_back(pk(vecs[i].er, 4'd0, vecs[i].eq));
         tick();
         sb_check($sformatf("vec%0d", i), pk(m_rco, 4'd0, m_q));
      end

      // RCO follows ENT combinationally at Q=9, no clock edge involved.
      ld_n = 1'b0; din = 4'd9; enp = 1'b0; ent = 1'b0;
      tick();
      ld_n = 1'b1; ent = 1'b1;
      #1 check("rco_ent_rise", pk(m_rco, 4'd0, m_q), pk(1'b1, 4'd0, 4'd9));
      ent = 1'b0;
      #1 check("rco_ent_fall", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd9));
      ent = 1'b1;
      #1 check("rco_ent_rise2", pk(m_rco, 4'd0, m_q), pk(1'b1, 4'd0, 4'd9));

      // Clear between edges at Q=5 with a count pending: discarded.
      ld_n = 1'b0; din = 4'd5; enp = 1'b0; ent = 1'b0;
      tick();
      check("pre_clear_q5", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd5));
      ld_n = 1'b1; enp = 1'b1; ent = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("clear_async", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd0));
      tick();
      check("clear_discard_edge", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd0));
      @(negedge clk);
      rst_n = 1'b1;
      ld_n = 1'b0; din = 4'd3;
      tick();
      check("first_edge_load", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd3));
      ld_n = 1'b1;
      tick();
      check("first_count_after", pk(m_rco, 4'd0, m_q), pk(1'b0, 4'd0, 4'd4));
      enp = 1'b0; ent = 1'b0;

      // Two-digit cascade: 100 edges from 00, high carry only at 99.
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      check("casc_start", pk(hi_rco, hi_q, lo_q), pk(1'b0, 4'd0, 4'd0));
      c_en = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         int n;
         n = i % 100;
         exp_q.push_back(pk(n == 99, 4'(n / 10), 4'(n % 10)));
         tick();
         sb_check($sformatf("casc%0d", i), pk(hi_rco, hi_q, lo_q));
      end
      c_en = 1'b0;

      // MODULUS 16 counter: 14 -> 15 (carry) -> 0, and 9 -> 10 is legal.
      ld16_n = 1'b0; d16 = 4'd14; en16 = 1'b0;
      exp_q.push_back(pk(1'b0, 4'd0, 4'd14));
      tick();
      sb_check("m16_load14", pk(h_rco, 4'd0, h_q));
      ld16_n = 1'b1; en16 = 1'b1;
      exp_q.push_back(pk(1'b1, 4'd0, 4'd15));
      tick();
      sb_check("m16_to15", pk(h_rco, 4'd0, h_q));
      exp_q.push_back(pk(1'b0, 4'd0, 4'd0));
      tick();
      sb_check("m16_wrap", pk(h_rco, 4'd0, h_q));
      ld16_n = 1'b0; d16 = 4'd9;
      exp_q.push_back(pk(1'b0, 4'd0, 4'd9));
      tick();
      sb_check("m16_load9", pk(h_rco, 4'd0, h_q));
      ld16_n = 1'b1;
      exp_q.push_back(pk(1'b0, 4'd0, 4'd10));
      tick();
      sb_check("m16_to10", pk(h_rco, 4'd0, h_q));
      en16 = 1'b0;

      check("sb_drained", 9'(exp_q.size()), 9'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
